vxc_add_sequencer: RTL and testbench
====================================

// Module: vxc_add_sequencer
// PURPOSE
//  Initiator/drain for the 8-lane conjugate-complex vXc-add unit (result = second_row op conj-mul(first_row, constant)).
//  Packs a serial operand stream (8 first-row elems, 8 second-row elems, 1 constant) into the unit's wide buses.
//  Runs the unit, captures its result vector on finish, and streams the 8 result elements back out serially.
//  Sits between the element-serial datapath/memory side and the wide vXc-add compute unit.
// PARAMETERS
//  NI             8    lanes per vector / elements per row
//  element_width  64   bits per complex element (opaque here, no arithmetic performed)
//  TIMEOUT        64   max RUN cycles waiting for unit_finish (used only with VXC_SEQ_TIMEOUT_EN)
// PORTS
//  clk              in   1                    clock, all logic on posedge
//  reset            in   1                    synchronous, active-high
//  cfg_op           in   1                    op for the run, sampled with first accepted input beat
//  in_valid         in   1                    input element valid
//  in_ready         out  1                    input element accepted when in_valid&&in_ready
//  in_data          in   element_width        operand element
//  out_valid        out  1                    result element valid
//  out_ready        in   1                    downstream accepts when out_valid&&out_ready
//  out_data         out  element_width        result element
//  out_last         out  1                    high with 8th (final) result element
//  unit_reset       out  1                    drives compute unit reset (doubles as its start/clear)
//  unit_first_row   out  element_width*NI     packed first-row vector
//  unit_second_row  out  element_width*NI     packed second-row vector
//  unit_constant    out  element_width        constant multiplier
//  unit_op          out  1                    add/sub select to unit
//  unit_result      in   element_width*NI     unit result vector
//  unit_finish      in   1                    unit done (sticky until unit_reset)
//  timeout_err      out  1                    sticky timeout flag (0 when macro off)
// BEHAVIOUR
//  Reset: state=LOAD, beat cnt=0, all operand/result regs 0, in_ready=0, out_valid=0, out_last=0,
//   out_data=0, unit_reset=1, unit_op=0, timeout_err=0. in_ready rises first cycle after reset drops.
//  Lane packing: element k (k=0..NI-1, k-th accepted) lands at bits [element_width*(NI-k)-1 -: element_width];
//   result unpacked/emitted in the same order (lane 0 = MSB slice first).
//  LOAD: in_ready=1, unit_reset=1. Beats 0..NI-1 -> first_row, NI..2NI-1 -> second_row, beat 2NI -> constant.
//   cfg_op latched into unit_op on beat 0. On accepting beat 2NI: cnt=0, -> RUN.
//  RUN: in_ready=0, unit_reset=0, all unit_* operand outputs held stable. unit_finish ignored in first RUN cycle
//   (clears stale finish). On unit_finish=1 (cycle >=2 of RUN): capture unit_result, unit_reset=1 next cycle, -> DRAIN.
//   Expected unit latency: finish 9 cycles after unit_reset falls; sequencer must not depend on exact count.
//  DRAIN: out_valid=1, out_data=captured lane cnt; advance only on out_ready. out_last=1 when cnt=NI-1.
//   On accepting last: out_valid=0, cnt=0, -> LOAD. out_data/out_last stable while stalled.
//  Back-to-back: new operands may be accepted the cycle after last result handshake; unit_reset high >=1 cycle between runs.
//  Reset mid-operation (any state): return to reset values immediately; partial vectors/results discarded.
//  in_valid while in_ready=0: ignored, no beat counted. Throughput: 2NI+1 + run latency + NI cycles min per op.
// CONFIGURATION
//  VXC_SEQ_TIMEOUT_EN defined: RUN counter; if unit_finish absent for TIMEOUT cycles, set timeout_err=1 (sticky
//   until reset), unit_reset=1, discard run, -> LOAD; no output emitted for that run.
//  Not defined: no counter, RUN waits indefinitely, timeout_err tied 0.
// TESTING
//  1 Load first_row elem k=64'h0000_0001_0000_000k, second_row=64'h0000_0010_0000_0000, const=64'h0000_0002_0000_0000,
//    op=0, unit model -> unit_first_row MSB slice = elem 0; 8 out beats match model in lane order, out_last on beat 8.
//  2 Same operands op=1 -> unit_op=1 throughout RUN; results equal model subtract values.
//  3 out_ready toggled 1,0,0,1 in DRAIN -> out_data held during stalls, exactly 8 beats, none lost/duplicated.
//  4 Two back-to-back ops -> unit_reset pulses high between runs; second result not polluted by first finish.
//  5 reset asserted at input beat 5 and again mid-DRAIN -> next clean 17-beat load produces correct 8 results.
//  6 VXC_SEQ_TIMEOUT_EN, TIMEOUT=64, unit_finish held 0 -> timeout_err=1 after 64 RUN cycles, back to LOAD, in_ready=1.

Source files
------------

// File: rtl/vxc_add_sequencer_if.sv
// Bundle of the stream and compute-unit signals around vxc_add_sequencer.
// master: the sequencer itself (accepts operand beats, drives the unit, emits results).
// slave:  the surroundings (operand source, result sink and the vXc-add unit).
interface vxc_add_sequencer_if #(
    parameter int NI            = 8,
    parameter int element_width = 64
);
    // operand input stream
    logic                        cfg_op;
    logic                        in_valid;
    logic                        in_ready;
    logic [element_width-1:0]    in_data;

    // result output stream
    logic                        out_valid;
    logic                        out_ready;
    logic [element_width-1:0]    out_data;
    logic                        out_last;

    // compute unit side
    logic                        unit_reset;
    logic [element_width*NI-1:0] unit_first_row;
    logic [element_width*NI-1:0] unit_second_row;
    logic [element_width-1:0]    unit_constant;
    logic                        unit_op;
    logic [element_width*NI-1:0] unit_result;
    logic                        unit_finish;

    // status
    logic                        timeout_err;

    modport master (
        input  cfg_op, in_valid, in_data, out_ready, unit_result, unit_finish,
        output in_ready, out_valid, out_data, out_last,
               unit_reset, unit_first_row, unit_second_row, unit_constant, unit_op,
               timeout_err
    );

    modport slave (
        output cfg_op, in_valid, in_data, out_ready, unit_result, unit_finish,
        input  in_ready, out_valid, out_data, out_last,
               unit_reset, unit_first_row, unit_second_row, unit_constant, unit_op,
               timeout_err
    );
endinterface

// File: rtl/vxc_add_sequencer.sv
// Initiator/drain for the 8-lane conjugate-complex vXc-add unit.
// Packs a serial operand stream (NI first-row elements, NI second-row elements,
// one constant) onto the unit's wide buses, runs the unit, captures its result
// vector and streams the NI result elements back out one per handshake.
// Lane k (k-th accepted element of a row) sits at the MSB end first:
//   bits [element_width*(NI-k)-1 -: element_width].
// Optional feature macro: VXC_SEQ_TIMEOUT_EN
//   defined   -> RUN watchdog; a run without unit_finish for TIMEOUT cycles is
//                abandoned, timeout_err set (sticky until reset), back to LOAD.
//   undefined -> RUN waits indefinitely and timeout_err is tied low.
// NI must be a power of two: the low bits of the beat counter double as the lane index.
module vxc_add_sequencer #(
    parameter int NI            = 8,
    parameter int element_width = 64,
    parameter int TIMEOUT       = 64
) (
    input  logic                clk,
    input  logic                reset,
    vxc_add_sequencer_if.master bus
);

    localparam int CNT_W  = $clog2(2*NI + 1);
    localparam int LANE_W = (NI > 1) ? $clog2(NI) : 1;

    localparam logic [CNT_W-1:0] BEAT_CONST = CNT_W'(2*NI);
    localparam logic [CNT_W-1:0] LANE_LAST  = CNT_W'(NI - 1);
    localparam logic [CNT_W-1:0] ROW_SPLIT  = CNT_W'(NI);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;

    logic                     in_ready_q;
    logic                     unit_reset_q;
    logic                     run_armed_q;

    logic [element_width-1:0] first_q  [NI];
    logic [element_width-1:0] second_q [NI];
    logic [element_width-1:0] constant_q;
    logic                     op_q;
    logic [element_width-1:0] result_q [NI];

    logic [element_width*NI-1:0] first_packed;
    logic [element_width*NI-1:0] second_packed;

    logic                     in_fire;
    logic                     out_fire;
    logic                     finish_seen;
    logic                     timeout_hit;
    logic [LANE_W-1:0]        lane_idx;

    assign lane_idx    = cnt_q[LANE_W-1:0];
    assign in_fire     = bus.in_valid && in_ready_q;
    assign out_fire    = (state_q == DRAIN) && bus.out_ready;
    // The first RUN cycle is skipped so a finish left over from a previous run cannot be taken.
    assign finish_seen = (state_q == RUN) && run_armed_q && bus.unit_finish;

`ifdef VXC_SEQ_TIMEOUT_EN
    localparam int RUN_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

    logic [RUN_W-1:0] run_cnt_q;
    logic             timeout_q;

    assign timeout_hit = (state_q == RUN) && !finish_seen && (run_cnt_q == RUN_LAST);

    // Watchdog: counts RUN cycles from zero on entry, latches a sticky error when it expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == RUN) begin
                run_cnt_q <= run_cnt_q + 1'b1;
            end else begin
                run_cnt_q <= '0;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Next-state and beat counter: LOAD counts operand beats, DRAIN counts result lanes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LOAD: begin
                if (in_fire) begin
                    if (cnt_q == BEAT_CONST) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (finish_seen) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (cnt_q == LANE_LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = LOAD;
            end
        endcase
    end

    // State register plus registered control outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            unit_reset_q <= 1'b1;
            run_armed_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= (state_d == LOAD);
            unit_reset_q <= (state_d != RUN);
            run_armed_q  <= (state_q == RUN) && (state_d == RUN);
        end
    end

    // Operand capture: beat selects first row, second row or constant; op latched on beat 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NI; k++) begin
                first_q[k]  <= '0;
                second_q[k] <= '0;
            end
            constant_q <= '0;
            op_q       <= 1'b0;
        end else if (in_fire) begin
            if (cnt_q == '0) begin
                op_q <= bus.cfg_op;
            end
            if (cnt_q < ROW_SPLIT) begin
                first_q[lane_idx] <= bus.in_data;
            end else if (cnt_q < BEAT_CONST) begin
                second_q[lane_idx] <= bus.in_data;
            end else begin
                constant_q <= bus.in_data;
            end
        end
    end

    // Result capture: the unit's vector is snapshotted once, on the accepted finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NI; k++) begin
                result_q[k] <= '0;
            end
        end else if (finish_seen) begin
            for (int k = 0; k < NI; k++) begin
                result_q[k] <= bus.unit_result[element_width*(NI-k)-1 -: element_width];
            end
        end
    end

    // Wide operand buses: lane 0 lands in the most significant slice.
    always_comb begin
        first_packed  = '0;
        second_packed = '0;
        for (int k = 0; k < NI; k++) begin
            first_packed[element_width*(NI-k)-1 -: element_width]  = first_q[k];
            second_packed[element_width*(NI-k)-1 -: element_width] = second_q[k];
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.unit_reset      = unit_reset_q;
    assign bus.unit_first_row  = first_packed;
    assign bus.unit_second_row = second_packed;
    assign bus.unit_constant   = constant_q;
    assign bus.unit_op         = op_q;

    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = (state_q == DRAIN) ? result_q[lane_idx] : '0;
    assign bus.out_last  = (state_q == DRAIN) && (cnt_q == LANE_LAST);

endmodule

// File: tb/tb_vxc_add_sequencer.sv
// Directed self-checking bench for vxc_add_sequencer with a behavioural vXc-add unit.
// Unit model: complex element = {real[63:32], imag[31:0]} (32-bit wrap),
//   result lane = second (+|-) conj(first) * constant, finish 9 cycles after unit_reset falls.
// Test 6 (watchdog) is only built when VXC_SEQ_TIMEOUT_EN is defined.
module tb_vxc_add_sequencer;

    localparam int NI = 8;
    localparam int W  = 64;

    localparam logic [W-1:0] ROW2  = 64'h0000_0010_0000_0000;
    localparam logic [W-1:0] CONST = 64'h0000_0002_0000_0000;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    logic             model_finish;
    logic [W*NI-1:0]  model_result;
    logic [7:0]       model_cnt;
    logic             model_block;

    vxc_add_sequencer_if #(.NI(NI), .element_width(W)) bus ();

    vxc_add_sequencer #(.NI(NI), .element_width(W), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.unit_finish = model_finish;
    assign bus.unit_result = model_result;

    function automatic logic [W-1:0] elem(input int k);
        return {32'h0000_0001, 32'(k)};
    endfunction

    // Hand-derived results for the fixed operand set: conj(1+jk)*2 = 2 - j2k.
    function automatic logic [W-1:0] expLane(input int k, input logic op);
        logic [31:0] two_k;
        two_k = 32'(2 * k);
        return op ? {32'h0000_000E, two_k} : {32'h0000_0012, 32'h0 - two_k};
    endfunction

    function automatic logic [W*NI-1:0] unitModel(input logic [W*NI-1:0] fr,
                                                  input logic [W*NI-1:0] sr,
                                                  input logic [W-1:0]    c,
                                                  input logic            op);
        logic [W*NI-1:0] res;
        logic [W-1:0]    a, b;
        logic [31:0]     pr, pi, rr, ri;
        res = '0;
        for (int k = 0; k < NI; k++) begin
            a  = fr[W*(NI-k)-1 -: W];
            b  = sr[W*(NI-k)-1 -: W];
            pr = a[63:32] * c[63:32] + a[31:0] * c[31:0];
            pi = a[63:32] * c[31:0]  - a[31:0] * c[63:32];
            rr = op ? b[63:32] - pr : b[63:32] + pr;
            ri = op ? b[31:0]  - pi : b[31:0]  + pi;
            res[W*(NI-k)-1 -: W] = {rr, ri};
        end
        return res;
    endfunction

    // Behavioural compute unit: cleared by unit_reset, sticky finish after a fixed latency.
    always @(posedge clk) begin
        if (bus.unit_reset) begin
            model_finish <= 1'b0;
            model_cnt    <= '0;
        end else if (!model_finish && !model_block) begin
            model_cnt <= model_cnt + 1'b1;
            if (model_cnt == 8'd8) begin
                model_finish <= 1'b1;
                model_result <= unitModel(bus.unit_first_row, bus.unit_second_row,
                                          bus.unit_constant, bus.unit_op);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [W*NI-1:0] observed,
                               input logic [W*NI-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One operand beat; called on a negedge, returns on the negedge after the handshake.
    task automatic applyStimulus(input logic [W-1:0] d, input logic op);
        int waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.cfg_op   = op;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("in_ready_wait", {511'b0, bus.in_ready}, 512'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic loadOperands(input logic op);
        for (int k = 0; k < NI; k++) applyStimulus(elem(k), op);
        for (int k = 0; k < NI; k++) applyStimulus(ROW2, op);
        applyStimulus(CONST, op);
    endtask

    // Waits out RUN, then takes nbeats results; stall applies out_ready pattern 1,0,0,1.
    task automatic drainBeats(input logic op, input logic stall, input int nbeats);
        int         beat, waited, ph;
        logic [3:0] pat;
        logic       rdy;
        beat   = 0;
        waited = 0;
        ph     = 0;
        pat    = 4'b1001;
        while (!bus.out_valid && waited < 200) begin
            if (!bus.unit_reset) checkOutput("run_unit_op", {511'b0, bus.unit_op}, {511'b0, op});
            @(negedge clk);
            waited++;
        end
        checkOutput("out_valid_rise", {511'b0, bus.out_valid}, 512'd1);
        if (!bus.out_valid) return;
        while (beat < nbeats && waited < 400) begin
            checkOutput($sformatf("out_valid_b%0d", beat), {511'b0, bus.out_valid}, 512'd1);
            checkOutput($sformatf("out_data_b%0d", beat), {448'b0, bus.out_data},
                        {448'b0, expLane(beat, op)});
            checkOutput($sformatf("out_last_b%0d", beat), {511'b0, bus.out_last},
                        {511'b0, (beat == NI - 1)});
            rdy           = stall ? pat[ph[1:0]] : 1'b1;
            ph++;
            bus.out_ready = rdy;
            @(negedge clk);
            if (rdy) beat++;
            waited++;
        end
        bus.out_ready = 1'b0;
        if (nbeats == NI) begin
            checkOutput("out_valid_after_last", {511'b0, bus.out_valid}, 512'd0);
            checkOutput("in_ready_after_last", {511'b0, bus.in_ready}, 512'd1);
            checkOutput("unit_reset_after_last", {511'b0, bus.unit_reset}, 512'd1);
        end
    endtask

    task automatic doReset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", {511'b0, bus.in_ready}, 512'd0);
        checkOutput("rst_out_valid", {511'b0, bus.out_valid}, 512'd0);
        checkOutput("rst_out_last", {511'b0, bus.out_last}, 512'd0);
        checkOutput("rst_out_data", {448'b0, bus.out_data}, 512'd0);
        checkOutput("rst_unit_reset", {511'b0, bus.unit_reset}, 512'd1);
        checkOutput("rst_unit_op", {511'b0, bus.unit_op}, 512'd0);
        checkOutput("rst_first_row", bus.unit_first_row, 512'd0);
        checkOutput("rst_second_row", bus.unit_second_row, 512'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", {511'b0, bus.in_ready}, 512'd1);
    endtask

    initial begin
        reset         = 1'b1;
        model_block   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_op    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_timeout_err", {511'b0, bus.timeout_err}, 512'd0);
        doReset();

        // Test 1: op=0, lane packing and ordered results; stray in_valid in RUN ignored.
        $display("[TB] test 1: add, lane order");
        loadOperands(1'b0);
        checkOutput("t1_first_msb", {448'b0, bus.unit_first_row[W*NI-1 -: W]}, {448'b0, elem(0)});
        checkOutput("t1_first_lsb", {448'b0, bus.unit_first_row[W-1:0]}, {448'b0, elem(7)});
        checkOutput("t1_second_msb", {448'b0, bus.unit_second_row[W*NI-1 -: W]}, {448'b0, ROW2});
        checkOutput("t1_constant", {448'b0, bus.unit_constant}, {448'b0, CONST});
        checkOutput("t1_unit_reset_run", {511'b0, bus.unit_reset}, 512'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t1_in_ready_run", {511'b0, bus.in_ready}, 512'd0);
        end
        bus.in_valid = 1'b0;
        drainBeats(1'b0, 1'b0, NI);

        // Test 2: op=1 held through RUN, subtract results.
        $display("[TB] test 2: subtract");
        loadOperands(1'b1);
        checkOutput("t2_unit_op", {511'b0, bus.unit_op}, 512'd1);
        drainBeats(1'b1, 1'b0, NI);

        // Test 3: stalled drain.
        $display("[TB] test 3: stalled drain");
        loadOperands(1'b0);
        drainBeats(1'b0, 1'b1, NI);

        // Test 4: back-to-back operations.
        $display("[TB] test 4: back-to-back");
        loadOperands(1'b0);
        drainBeats(1'b0, 1'b0, NI);
        loadOperands(1'b1);
        drainBeats(1'b1, 1'b0, NI);

        // Test 5: reset during load and during drain, then a clean run.
        $display("[TB] test 5: reset mid-operation");
        for (int k = 0; k < 5; k++) applyStimulus(elem(k), 1'b1);
        doReset();
        loadOperands(1'b1);
        drainBeats(1'b1, 1'b0, 3);
        doReset();
        loadOperands(1'b0);
        drainBeats(1'b0, 1'b0, NI);

`ifdef VXC_SEQ_TIMEOUT_EN
        // Test 6: unit never finishes, watchdog returns to LOAD.
        $display("[TB] test 6: timeout");
        model_block = 1'b1;
        loadOperands(1'b0);
        repeat (63) @(negedge clk);
        checkOutput("t6_err_before", {511'b0, bus.timeout_err}, 512'd0);
        checkOutput("t6_in_ready_before", {511'b0, bus.in_ready}, 512'd0);
        @(negedge clk);
        checkOutput("t6_err_after", {511'b0, bus.timeout_err}, 512'd1);
        checkOutput("t6_in_ready_after", {511'b0, bus.in_ready}, 512'd1);
        checkOutput("t6_unit_reset_after", {511'b0, bus.unit_reset}, 512'd1);
        model_block = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("t6_no_output", {511'b0, bus.out_valid}, 512'd0);
        loadOperands(1'b1);
        drainBeats(1'b1, 1'b0, NI);
        checkOutput("t6_err_sticky", {511'b0, bus.timeout_err}, 512'd1);
`else
        checkOutput("timeout_err_tied", {511'b0, bus.timeout_err}, 512'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
